// File: rtl/secant_ctrl.sv
// secant_ctrl: drives a current reference into a plant and runs a secant-method
// search for the reference that makes the measured response hit q_desired.
// Optional build macro: SECANT_TIMEOUT_EN adds a per-measurement timeout that
// aborts the search to FAIL when the plant does not answer in TIMEOUT cycles.
module secant_ctrl #(
    parameter int unsigned BUS_WIDTH = 10,
    parameter int unsigned TOL       = 30,
    parameter int unsigned MAX_ITER  = 16,
    parameter int unsigned A_INIT    = 0,
    parameter int unsigned B_INIT    = (1 << BUS_WIDTH) - 2,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned IW       = $clog2(MAX_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] q_desired,
    input  logic [BUS_WIDTH-1:0] q_measured,
    input  logic                 meas_valid,
    output logic [BUS_WIDTH-1:0] i_ref,
    output logic                 i_ref_valid,
    output logic                 busy,
    output logic                 converged,
    output logic                 went_unstable,
    output logic [IW-1:0]        iter_count
);

    localparam int unsigned W        = BUS_WIDTH;
    localparam int unsigned DW       = 2 * W + 2;
    localparam int unsigned EW       = W + 2;
    localparam int unsigned CNTW     = $clog2(DW);
    localparam int unsigned DIV_LAST = DW - 1;

    typedef enum logic [3:0] {
        IDLE, APPLY_A, WAIT_A, APPLY_B, WAIT_B, CALC,
        DIV, APPLY_C, WAIT_C, CHECK, DONE, FAIL
    } state_t;

    state_t          state;
    logic [W-1:0]    a, b, c, f_a, f_b, f_c, q_des;
    logic [DW-1:0]   dvd, quo;
    logic [W-1:0]    dvs, rem;
    logic            neg;
    logic [CNTW-1:0] div_cnt;
    logic            tmo_hit;

    // Signed differences of the operands; EW bits hold any difference of two W-bit values
    logic signed [EW-1:0] fb_err, dx, fd, fc_err;
    assign fb_err = $signed({2'b00, f_b}) - $signed({2'b00, q_des});
    assign dx     = $signed({2'b00, b})   - $signed({2'b00, a});
    assign fd     = $signed({2'b00, f_b}) - $signed({2'b00, f_a});
    assign fc_err = $signed({2'b00, f_c}) - $signed({2'b00, q_des});

    // Secant numerator/denominator and their magnitudes for the unsigned divider
    logic signed [DW-1:0] num_c, den_c;
    logic [DW-1:0]        num_abs;
    logic [W-1:0]         den_abs;
    logic [EW-1:0]        err_abs;
    logic                 close_c;
    assign num_c   = DW'(fb_err) * DW'(dx);
    assign den_c   = DW'(fd);
    assign num_abs = num_c[DW-1] ? $unsigned(-num_c) : $unsigned(num_c);
    assign den_abs = W'(fd[EW-1] ? -fd : fd);
    assign err_abs = fc_err[EW-1] ? $unsigned(-fc_err) : $unsigned(fc_err);
    assign close_c = err_abs < TOL[EW-1:0];

    // One restoring-division step plus the saturated candidate built from its result
    logic [W:0]          rem_sh;
    logic                q_bit;
    logic [W-1:0]        rem_nxt;
    logic [DW-1:0]       quo_nxt;
    logic signed [DW:0]  quo_s, c_wide;
    logic [W-1:0]        c_sat;
    assign rem_sh  = {rem, dvd[DW-1]};
    assign q_bit   = rem_sh >= {1'b0, dvs};
    assign rem_nxt = q_bit ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];
    assign quo_nxt = {quo[DW-2:0], q_bit};
    assign quo_s   = neg ? -$signed({1'b0, quo_nxt}) : $signed({1'b0, quo_nxt});
    assign c_wide  = $signed({{(DW + 1 - W){1'b0}}, b}) - quo_s;
    assign c_sat   = c_wide[DW] ? '0 : ((|c_wide[DW-1:W]) ? '1 : c_wide[W-1:0]);

`ifdef SECANT_TIMEOUT_EN
    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam int unsigned TMO_LAST = TIMEOUT - 2;
    logic [TW-1:0] tmo_cnt;
    logic          in_wait;
    assign in_wait = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_C);

    // Idle cycles spent in the current WAIT state; request pulse plus WAIT cycles span TIMEOUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (in_wait && !meas_valid) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
    assign tmo_hit = in_wait && !meas_valid && (tmo_cnt == TMO_LAST[TW-1:0]);
`else
    assign tmo_hit = 1'b0;
`endif

    // Search sequencer: apply bounds, measure, divide, apply candidate, check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            i_ref         <= '0;
            i_ref_valid   <= 1'b0;
            busy          <= 1'b0;
            converged     <= 1'b0;
            went_unstable <= 1'b0;
            iter_count    <= '0;
            a             <= '0;
            b             <= '0;
            c             <= '0;
            f_a           <= '0;
            f_b           <= '0;
            f_c           <= '0;
            q_des         <= '0;
            dvd           <= '0;
            dvs           <= '0;
            rem           <= '0;
            quo           <= '0;
            neg           <= 1'b0;
            div_cnt       <= '0;
        end else begin
            i_ref_valid <= 1'b0;
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        converged     <= 1'b0;
                        went_unstable <= 1'b0;
                        iter_count    <= '0;
                        busy          <= 1'b1;
                        q_des         <= q_desired;
                        a             <= A_INIT[W-1:0];
                        b             <= B_INIT[W-1:0];
                        i_ref         <= A_INIT[W-1:0];
                        i_ref_valid   <= 1'b1;
                        state         <= APPLY_A;
                    end
                end
                APPLY_A: state <= WAIT_A;
                WAIT_A: begin
                    if (meas_valid) begin
                        f_a         <= q_measured;
                        i_ref       <= b;
                        i_ref_valid <= 1'b1;
                        state       <= APPLY_B;
                    end else if (tmo_hit) begin
                        busy          <= 1'b0;
                        went_unstable <= 1'b1;
                        state         <= FAIL;
                    end
                end
                APPLY_B: state <= WAIT_B;
                WAIT_B: begin
                    if (meas_valid) begin
                        f_b   <= q_measured;
                        state <= CALC;
                    end else if (tmo_hit) begin
                        busy          <= 1'b0;
                        went_unstable <= 1'b1;
                        state         <= FAIL;
                    end
                end
                CALC: begin
                    if (den_c == '0) begin
                        busy          <= 1'b0;
                        went_unstable <= 1'b1;
                        state         <= FAIL;
                    end else begin
                        dvd     <= num_abs;
                        dvs     <= den_abs;
                        rem     <= '0;
                        quo     <= '0;
                        neg     <= num_c[DW-1] ^ den_c[DW-1];
                        div_cnt <= '0;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    rem     <= rem_nxt;
                    dvd     <= {dvd[DW-2:0], 1'b0};
                    quo     <= quo_nxt;
                    div_cnt <= div_cnt + CNTW'(1);
                    if (div_cnt == DIV_LAST[CNTW-1:0]) begin
                        c           <= c_sat;
                        i_ref       <= c_sat;
                        i_ref_valid <= 1'b1;
                        state       <= APPLY_C;
                    end
                end
                APPLY_C: state <= WAIT_C;
                WAIT_C: begin
                    if (meas_valid) begin
                        f_c   <= q_measured;
                        state <= CHECK;
                    end else if (tmo_hit) begin
                        busy          <= 1'b0;
                        went_unstable <= 1'b1;
                        state         <= FAIL;
                    end
                end
                CHECK: begin
                    iter_count <= iter_count + IW'(1);
                    if (close_c) begin
                        busy      <= 1'b0;
                        converged <= 1'b1;
                        state     <= DONE;
                    end else begin
                        a   <= b;
                        f_a <= f_b;
                        b   <= c;
                        f_b <= f_c;
                        if (iter_count + IW'(1) == MAX_ITER[IW-1:0]) begin
                            busy          <= 1'b0;
                            went_unstable <= 1'b1;
                            state         <= FAIL;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secant_ctrl.sv
// tb_secant_ctrl: directed vectors against a behavioural plant for secant_ctrl.
module tb_secant_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] q_desired;
    logic [9:0] q_measured;
    logic       meas_valid;
    logic [9:0] i_ref;
    logic       i_ref_valid;
    logic       busy;
    logic       converged;
    logic       went_unstable;
    logic [4:0] iter_count;

    logic       plant_mv = 1'b0;
    logic       stray_mv = 1'b0;
    logic [9:0] plant_q  = '0;
    logic [9:0] cap;
    int         plant_mode = 0;
    bit         plant_en   = 1'b1;

    assign meas_valid = plant_mv | stray_mv;
    assign q_measured = plant_q;

    secant_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .q_desired     (q_desired),
        .q_measured    (q_measured),
        .meas_valid    (meas_valid),
        .i_ref         (i_ref),
        .i_ref_valid   (i_ref_valid),
        .busy          (busy),
        .converged     (converged),
        .went_unstable (went_unstable),
        .iter_count    (iter_count)
    );

    always #5 clk = ~clk;

    // Plant responses: 0 linear i/2+10, 1 constant 100, 2/3 linear with a kink at 496
    function automatic logic [9:0] plant_f(input int mode, input logic [9:0] i);
        logic [9:0] r;
        r = 10'(i >> 1) + 10'd10;
        case (mode)
            1: r = 10'd100;
            2: if (i == 10'd496) r = 10'd287;
            3: if (i == 10'd496) r = 10'd288;
            default: ;
        endcase
        return r;
    endfunction

    // Plant answers each request three cycles into the WAIT state
    initial begin
        @(posedge clk); #1;
        forever begin
            if (i_ref_valid && plant_en && rst) begin
                cap = i_ref;
                @(posedge clk); #1;
                repeat (2) begin @(posedge clk); #1; end
                plant_q  = plant_f(plant_mode, cap);
                plant_mv = 1'b1;
                @(posedge clk); #1;
                plant_mv = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // Monitor: records applied references and event cycles for the current run
    int seq[$];
    int iv_cyc[$];
    int mv_cyc[$];
    int unst_cyc = -1;
    int cyc = 0;
    int run_id = 0;
    int seen_id = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (run_id != seen_id) begin
            seen_id = run_id;
            seq.delete();
            iv_cyc.delete();
            mv_cyc.delete();
            unst_cyc = -1;
        end
        if (i_ref_valid) begin
            seq.push_back(int'(i_ref));
            iv_cyc.push_back(cyc);
        end
        if (meas_valid && busy) mv_cyc.push_back(cyc);
        if (went_unstable && unst_cyc < 0) unst_cyc = cyc;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [9:0] qd;
        int         mode;
        int         nseq;
        int         s[5];
        bit         conv;
        bit         unst;
        int         iter;
        int         iref;
    } vec_t;

    vec_t vt[6];

    function automatic vec_t mk(input logic [9:0] qd, input int mode, input int nseq,
                                input int s0, input int s1, input int s2, input int s3,
                                input int s4, input bit conv, input bit unst,
                                input int iter, input int iref);
        vec_t v;
        v.qd = qd; v.mode = mode; v.nseq = nseq;
        v.s  = '{s0, s1, s2, s3, s4};
        v.conv = conv; v.unst = unst; v.iter = iter; v.iref = iref;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic kick(input logic [9:0] qd);
        @(posedge clk); #1;
        run_id    = run_id + 1;
        q_desired = qd;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Waits for busy to drop; optionally pulses start once while in WAIT_B
    task automatic wait_idle(input bit inject, output bit ok);
        bit fired;
        ok = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (inject && !fired && iv_cyc.size() == 2) begin
                start = 1'b1;
                fired = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic check_vec(input int idx, input string tag);
        int act;
        chk({tag, "_converged"}, int'(converged), int'(vt[idx].conv));
        chk({tag, "_unstable"}, int'(went_unstable), int'(vt[idx].unst));
        chk({tag, "_iter"}, int'(iter_count), vt[idx].iter);
        chk({tag, "_iref"}, int'(i_ref), vt[idx].iref);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_nseq"}, seq.size(), vt[idx].nseq);
        for (int k = 0; k < vt[idx].nseq; k++) begin
            act = (k < seq.size()) ? seq[k] : -1;
            chk($sformatf("%s_seq%0d", tag, k), act, vt[idx].s[k]);
        end
        if (vt[idx].nseq >= 3) begin
            act = (iv_cyc.size() >= 3 && mv_cyc.size() >= 2) ? iv_cyc[2] - mv_cyc[1] : -1;
            chk({tag, "_latency"}, act, 24);
        end
    endtask

    task automatic run_vec(input int idx, input bit stray, input bit inject, input string tag);
        bit ok;
        plant_mode = vt[idx].mode;
        if (stray) begin
            @(posedge clk); #1;
            stray_mv = 1'b1;
            @(posedge clk); #1;
            stray_mv = 1'b0;
        end
        kick(vt[idx].qd);
        wait_idle(inject, ok);
        chk({tag, "_finished"}, int'(ok), 1);
        check_vec(idx, tag);
    endtask

    initial begin
        bit found;
        rst       = 1'b0;
        start     = 1'b0;
        q_desired = '0;

        vt[0] = mk(10'd258, 0, 3, 0, 1022, 496, 0, 0, 1'b1, 1'b0, 1, 496);
        vt[1] = mk(10'd258, 1, 2, 0, 1022, 0, 0, 0, 1'b0, 1'b1, 0, 1022);
        vt[2] = mk(10'd600, 0, 3, 0, 1022, 1023, 0, 0, 1'b0, 1'b1, 1, 1023);
        vt[3] = mk(10'd10, 0, 3, 0, 1022, 0, 0, 0, 1'b1, 1'b0, 1, 0);
        vt[4] = mk(10'd258, 2, 3, 0, 1022, 496, 0, 0, 1'b1, 1'b0, 1, 496);
        vt[5] = mk(10'd258, 3, 5, 0, 1022, 496, 429, 464, 1'b1, 1'b0, 3, 464);

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_iref", int'(i_ref), 0);
        chk("rst_ivalid", int'(i_ref_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_conv", int'(converged), 0);
        chk("rst_unst", int'(went_unstable), 0);
        chk("rst_iter", int'(iter_count), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_vec(v, 1'b0, 1'b0, $sformatf("v%0d", v));
        end

        // Stray meas_valid before start and start during WAIT_B are both ignored
        run_vec(0, 1'b1, 1'b1, "ignore");

        // Asynchronous reset in the fifth DIV cycle, then a fresh search
        plant_mode = 0;
        kick(10'd258);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mv_cyc.size() == 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("div_reach", int'(found), 1);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_iref", int'(i_ref), 0);
        chk("midrst_ivalid", int'(i_ref_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_conv", int'(converged), 0);
        chk("midrst_unst", int'(went_unstable), 0);
        chk("midrst_iter", int'(iter_count), 0);
        @(negedge clk);
        rst = 1'b1;
        run_vec(0, 1'b0, 1'b0, "after_rst");

        // Silent plant
        plant_en = 1'b0;
        kick(10'd258);
`ifdef SECANT_TIMEOUT_EN
        for (int i = 0; i < 600; i++) begin
            if (went_unstable) break;
            @(posedge clk); #1;
        end
        chk("tmo_unst", int'(went_unstable), 1);
        chk("tmo_busy", int'(busy), 0);
        chk("tmo_latency", (iv_cyc.size() >= 1 && unst_cyc >= 0) ? unst_cyc - iv_cyc[0] : -1, 255);
`else
        repeat (1100) @(posedge clk);
        #1;
        chk("hang_busy", int'(busy), 1);
        chk("hang_unst", int'(went_unstable), 0);
        chk("hang_nseq", seq.size(), 1);
`endif
        do_reset();
        plant_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/secant_ctrl.md
SECANT_CTRL -- requirements
Module: secant_ctrl

Interface
REQ-001 BUS_WIDTH, 10, width of the current reference and measurement buses.
REQ-002 TOL, 30, convergence threshold; converged when |f_c - q_desired| < TOL.
REQ-003 MAX_ITER, 16, maximum secant updates before the search is declared unstable.
REQ-004 A_INIT, 0, first bound applied as i_ref.
REQ-005 B_INIT, 2**BUS_WIDTH-2, second bound applied as i_ref.
REQ-006 TIMEOUT, 255, cycles allowed per measurement (used only with SECANT_TIMEOUT_EN).
REQ-007 clk  in  1  single clock; all state changes on posedge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse that begins a search from IDLE, DONE or FAIL.
REQ-010 q_desired  in  BUS_WIDTH  target measurement, unsigned, sampled on accepted start.
REQ-011 q_measured  in  BUS_WIDTH  plant response to the current i_ref, unsigned.
REQ-012 meas_valid  in  1  q_measured is valid for the most recent i_ref_valid.
REQ-013 i_ref  out  BUS_WIDTH  current reference driven to the plant, registered.
REQ-014 i_ref_valid  out  1  one-cycle pulse when i_ref takes a new value and a measurement is requested.
REQ-015 busy  out  1  high in every state except IDLE, DONE and FAIL.
REQ-016 converged  out  1  high in DONE until the next accepted start or reset.
REQ-017 went_unstable  out  1  high in FAIL until the next accepted start or reset.
REQ-018 iter_count  out  $clog2(MAX_ITER+1)  number of completed secant updates in the current search.

Function
REQ-019 The controller SHALL have states IDLE, APPLY_A, WAIT_A, APPLY_B, WAIT_B, CALC, DIV, APPLY_C, WAIT_C, CHECK, DONE and FAIL.
REQ-020 start SHALL be accepted only in IDLE/DONE/FAIL and ignored while busy; acceptance clears converged, went_unstable and iter_count, loads a=A_INIT, b=B_INIT and goes to APPLY_A.
REQ-021 Each APPLY_x state SHALL last one cycle, drive i_ref=x and pulse i_ref_valid; the next state is WAIT_x.
REQ-022 Each WAIT_x state SHALL latch q_measured into f_x on the first cycle meas_valid=1; meas_valid outside WAIT states SHALL be ignored.
REQ-023 CALC SHALL form num=(f_b-q_desired)*(b-a) and den=f_b-f_a as signed values of 2*BUS_WIDTH+2 bits with no overflow; den==0 SHALL go to FAIL, otherwise to DIV.
REQ-024 DIV SHALL run a sequential restoring divider of exactly 2*BUS_WIDTH+2 cycles, quotient truncated toward zero.
REQ-025 c=b-quotient SHALL be saturated to [0, 2**BUS_WIDTH-1] before APPLY_C.
REQ-026 CHECK SHALL take one cycle: if |f_c-q_desired| < TOL it goes to DONE; otherwise a<=b, f_a<=f_b, b<=c, f_b<=f_c, iter_count increments, and the controller goes to FAIL if iter_count reaches MAX_ITER, else to CALC.
REQ-027 i_ref SHALL hold its last value in DONE and FAIL; the iteration that converges SHALL count toward iter_count.
REQ-028 Latency from the last meas_valid of WAIT_B to i_ref_valid for c SHALL be 2*BUS_WIDTH+4 cycles.

Reset
REQ-029 Reset SHALL force IDLE, i_ref=0, i_ref_valid=0, busy=0, converged=0, went_unstable=0, iter_count=0, and clear a, b, c, f_a, f_b, f_c and the divider, including during DIV or WAIT states.

Configuration
REQ-030 With SECANT_TIMEOUT_EN defined, a per-WAIT counter SHALL go to FAIL when TIMEOUT cycles pass without meas_valid; without it, WAIT states SHALL wait indefinitely and no counter logic SHALL be present.

Verification
REQ-031 Plant q=i_ref/2+10, BUS_WIDTH=10, q_desired=258, start -> i_ref sequence 0, 1022, 496; converged=1, iter_count=1.
REQ-032 Plant q=100 constant, start -> den==0 after WAIT_B; went_unstable=1, i_ref held at 1022, iter_count=0.
REQ-033 Plant q=i_ref/2+10, q_desired=600 -> c saturates to 1023, then den==0; went_unstable=1, iter_count=1.
REQ-034 SECANT_TIMEOUT_EN, TIMEOUT=255, no meas_valid after the first i_ref_valid -> went_unstable=1 exactly 255 cycles later; without the macro the controller stays busy for more than 1000 cycles.
REQ-035 rst asserted in cycle 5 of DIV, then released, then start -> all outputs return to their reset values immediately, and the new search reproduces the REQ-031 result.
REQ-036 start pulsed during WAIT_B, and meas_valid pulsed in IDLE -> both ignored; the sequence and result match REQ-031.
